// File: rtl/trdb_resync_handler.sv
// Resync loop closer: on counter saturation, waits for an anchor instruction,
// requests a sync packet, then pulses the counter clear once the packet is accepted.
module trdb_resync_handler #(
  parameter int WAIT_TIMEOUT = 4096,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 trace_enabled_i,
  input  logic                 resync_max_i,
  input  logic                 inst_valid_i,
  input  logic                 sync_ack_i,
  output logic                 sync_req_o,
  output logic                 resync_rst_o,
  output logic                 resync_pending_o,
  output logic                 resync_stall_o,
  output logic [CNT_WIDTH-1:0] resync_count_o
);

  localparam int              WW       = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(WAIT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_INST = 3'd1,
    REQ       = 3'd2,
    CLEAR     = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [WW-1:0]        wait_cnt, wait_nxt;
  logic                 stall_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 pending;

  always_comb begin
    state_nxt        = state;
    sync_req_o       = 1'b0;
    resync_rst_o     = 1'b0;
    resync_pending_o = 1'b0;
    case (state)
      IDLE: begin
        if (resync_max_i && trace_enabled_i) state_nxt = WAIT_INST;
      end
      WAIT_INST: begin
        resync_pending_o = 1'b1;
        if (!trace_enabled_i)  state_nxt = IDLE;
        else if (inst_valid_i) state_nxt = REQ;
      end
      REQ: begin
        sync_req_o       = 1'b1;
        resync_pending_o = 1'b1;
        // A completed handshake takes precedence over a simultaneous disable.
        if (sync_ack_i)            state_nxt = CLEAR;
        else if (!trace_enabled_i) state_nxt = IDLE;
      end
      CLEAR: begin
        resync_rst_o = 1'b1;
        state_nxt    = HOLDOFF;
      end
      HOLDOFF: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pending   = (state == WAIT_INST) || (state == REQ);
  assign wait_nxt  = !pending ? '0 :
                     (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);
  assign stall_nxt = trace_enabled_i && (resync_stall_o || (pending && (wait_nxt == WAIT_MAX)));
  assign count_nxt = (state == REQ && sync_ack_i) ? resync_count_o + CNT_WIDTH'(1)
                                                   : resync_count_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      resync_stall_o <= 1'b0;
      resync_count_o <= '0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_nxt;
      resync_stall_o <= stall_nxt;
      resync_count_o <= count_nxt;
    end
  end

endmodule
